// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int TWOS_NEG_MAX_W = 64;

    // Two's-complement negation of the low 'width' bits of value; bits above
    // 'width' are returned as zero so callers can slice without cleanup.
    function automatic logic [TWOS_NEG_MAX_W-1:0] twos_neg(
        input logic [TWOS_NEG_MAX_W-1:0] value,
        input int                        width
    );
        logic [TWOS_NEG_MAX_W-1:0] mask;
        if (width >= TWOS_NEG_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        return (~value + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/cla_addn.sv
// N-bit adder built from generate/propagate terms: sum = a + b + cin.
module cla_addn #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry is resolved bit by bit from generate/propagate; carry-out is not needed.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = prop[i] ^ carry;
            carry  = gen[i] | (prop[i] & carry);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed or unsigned, one multiplier bit per cycle.
// Signed operands are multiplied as magnitudes and the product negated at the end.
// Optional macro SEQ_MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero (minimum one RUN cycle); results are unchanged.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add/shift iteration per cycle, busy=1
// DONE  | result valid, done=1 for this single cycle; start here chains a new op
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    mul_state_t state;
    mul_state_t state_nxt;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] sum;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] acc_final;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               neg;
    logic [CNT_W-1:0]   cnt;
    logic               last_iter;
    logic               accept;

    assign accept = start && ((state == IDLE) || (state == DONE));

    // Operand conditioning: magnitudes in signed mode, pass-through otherwise.
    always_comb begin
        logic [63:0] a_neg;
        logic [63:0] b_neg;
        a_neg = twos_neg(64'(A), WIDTH);
        b_neg = twos_neg(64'(B), WIDTH);
        a_abs = (is_signed && A[WIDTH-1]) ? a_neg[WIDTH-1:0] : A;
        b_abs = (is_signed && B[WIDTH-1]) ? b_neg[WIDTH-1:0] : B;
    end

    cla_addn #(
        .N(2*WIDTH)
    ) u_add (
        .a   (acc),
        .b   (mcand),
        .cin (1'b0),
        .sum (sum)
    );

    assign acc_nxt = mplier[0] ? sum : acc;

    // Final product, sign applied; taken from acc_nxt so the last add is included.
    always_comb begin
        logic [63:0] acc_neg;
        acc_neg   = twos_neg(64'(acc_nxt), 2*WIDTH);
        acc_final = neg ? acc_neg[2*WIDTH-1:0] : acc_nxt;
    end

`ifdef SEQ_MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_iter ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: capture operands on accept, iterate in RUN, load result on the last iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_abs};
            mplier <= b_abs;
            neg    <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (last_iter) begin
                result <= acc_final;
            end
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1): iteration counter width, derived, not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE or DONE.
REQ-006 SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have port A, input, WIDTH bits: multiplicand; sampled with start.
REQ-008 SHALL have port B, input, WIDTH bits: multiplier; sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, 2*WIDTH bits: product; held stable from the done cycle until the next accepted start.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL capture A, B and is_signed, clear the accumulator, and enter RUN next cycle.
REQ-014 Operand conditioning SHALL be: signed mode stores |A| and |B| as WIDTH-bit unsigned values and records neg = A[MSB]^B[MSB]; unsigned mode stores the operands as-is with neg=0.
REQ-015 Each RUN cycle SHALL add the shifted multiplicand to the 2*WIDTH accumulator when the multiplier LSB is 1, then shift the multiplicand left by 1, shift the multiplier right by 1, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; done SHALL be high in the cycle WIDTH+1 clocks after the start-sampling edge (9 for WIDTH=8).
REQ-017 On leaving RUN, result SHALL load the accumulator, or its two's-complement negation (mod 2^(2*WIDTH)) if neg=1.
REQ-018 DONE SHALL last one cycle; it SHALL go to RUN if start=1 (back-to-back) and to IDLE otherwise.
REQ-019 start asserted during RUN SHALL be ignored, with no queuing.
REQ-020 Arithmetic SHALL be exact for every input: -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), with no overflow.
REQ-021 busy and done SHALL never be high in the same cycle.

Reset
REQ-022 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, result=0, accumulator=0 and counter=0, including when asserted mid-RUN; the in-flight operation is discarded and no done is produced.
REQ-023 start in the same cycle as rst SHALL be ignored.

Configuration
REQ-024 Macro SEQ_MUL_EARLY_TERM_EN SHALL control early termination of RUN.
- Defined: RUN ends after the current cycle once the remaining multiplier bits are all zero.
- Defined: minimum RUN length is 1 cycle, so B=0 gives done 2 clocks after start.
- Undefined: RUN length is always WIDTH cycles.
- Result values are identical either way.

Structure
REQ-025 Package seq_mul_pkg SHALL hold the FSM state enum (mul_state_t: IDLE, RUN, DONE).
REQ-026 Package seq_mul_pkg SHALL also hold a function twos_neg(value, width) used for operand abs and result negation.
REQ-027 The 2*WIDTH-bit accumulate adder SHALL be a separate parametrised sub-module, cla_addn (parameter N), with combinational sum = a + b + cin.

Verification (WIDTH=8)
REQ-028 Unsigned case: A=13, B=11, is_signed=0 -> result=16'h008F, done exactly 9 clocks after start, busy high for 8 cycles.
REQ-029 Extremes:
- A=255, B=255 unsigned -> 16'hFE01.
- A=8'h80, B=8'h80 signed -> 16'h4000.
- A=8'hFD (-3), B=5 signed -> 16'hFFF1.
REQ-030 Start during RUN: second start mid-RUN with different operands -> ignored, first product delivered.
REQ-031 Back-to-back: start held through the DONE cycle -> new operation begins immediately, no IDLE cycle.
REQ-032 Reset mid-RUN: rst asserted on the 4th RUN cycle -> next cycle busy=0, done=0, result=0, and no done pulse follows.
REQ-033 Early termination: A=7, B=0 -> result=0.
- With SEQ_MUL_EARLY_TERM_EN: done 2 clocks after start.
- Without SEQ_MUL_EARLY_TERM_EN: done 9 clocks after start.
- B=1 with the macro: done 2 clocks after start.
